seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_pkg.sv | 17 +
 rtl/sevenSeg.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Minimum counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/sevenSeg.sv
// Hex-to-seven-segment decoder, active-low segments, bit0 = a .. bit6 = g.
module sevenSeg
  import seg_scan_ctrl_pkg::*;
(
  input  nibble_t hex,
  output seg_t    seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value
// updates, leading-zero blanking and whole-display blink.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output seg_t                    seven_seg,
  output logic                    frame_tick
);

  localparam int unsigned PreW  = cnt_width(PRESCALE);
  localparam int unsigned IdxW  = cnt_width(NUM_DIGITS);
  localparam int unsigned FrW   = cnt_width(BLINK_DIV);
  localparam int unsigned DataW = 4 * NUM_DIGITS;

  logic [PreW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [FrW-1:0]        frame_q, frame_d;
  logic                  blink_q, blink_d;
  logic [DataW-1:0]      disp_q, disp_d;
  logic [DataW-1:0]      pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  tick_q;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  seg_t                  seg_q, seg_d;

  logic                  slot_end, last_digit, boundary, xfer;
  nibble_t               cur_nib;
  logic                  cur_blank;
  seg_t                  dec_seg;
  logic [NUM_DIGITS-1:0] upper_zero;

  assign slot_end   = (presc_q == PreW'(PRESCALE - 1));
  assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign boundary   = slot_end && last_digit;
  assign xfer       = load_valid && ready_q;

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + PreW'(1);
    idx_d   = idx_q;
    if (slot_end) idx_d = last_digit ? '0 : idx_q + IdxW'(1);

    frame_d = frame_q;
    blink_d = blink_q;
    if (boundary) begin
      if (frame_q == FrW'(BLINK_DIV - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FrW'(1);
      end
    end

    // A transfer needs an empty buffer and a commit a full one, so they never coincide;
    // a transfer on the boundary therefore waits for the following boundary.
    pend_d  = pend_q;
    disp_d  = disp_q;
    ready_d = ready_q;
    if (xfer) begin
      pend_d  = load_data;
      ready_d = 1'b0;
    end else if (boundary && !ready_q) begin
      disp_d  = pend_q;
      ready_d = 1'b1;
    end
  end

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the display register are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (disp_q[DataW-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = disp_q[4*i +: 4];
        cur_blank = blank_lz && (i != 0) && upper_zero[i];
      end
    end
  end

  sevenSeg u_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    sel_d = '1;
    seg_d = SEG_BLANK;
    if (!(blink_en && blink_q)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IdxW'(i)) sel_d[i] = 1'b0;
      end
      seg_d = cur_blank ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      disp_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
      tick_q  <= 1'b0;
      sel_q   <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      tick_q  <= boundary;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign load_ready = ready_q;
  assign digit_sel  = sel_q;
  assign seven_seg  = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=4, NUM_DIGITS=4, BLINK_DIV=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = 16'h0000;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  digit_sel;
  logic [6:0]  seven_seg;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;
  int cyc   = -1;  // index of the most recent rising edge since reset release

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .PRESCALE   (4),
    .BLINK_DIV  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .digit_sel  (digit_sel),
    .seven_seg  (seven_seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pos(input int p);
    for (int n = 0; n < 16; n++) begin
      step();
      if (cyc % 16 == p) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests++; if (digit_sel !== 4'hF) begin fails++; $display("FAIL reset_sel got %h want f", digit_sel); end
    tests++; if (seven_seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seven_seg); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", load_ready); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", frame_tick); end
  endtask

  task automatic test_scan();
    logic [3:0] es;
    rst = 1'b0;
    cyc = -1;
    for (int k = 0; k < 32; k++) begin
      step();
      es = ~(4'b0001 << ((cyc % 16) / 4));
      tests++; if (digit_sel !== es) begin fails++; $display("FAIL scan_sel cyc %0d got %b want %b", cyc, digit_sel, es); end
      tests++; if (seven_seg !== 7'h40) begin fails++; $display("FAIL scan_seg cyc %0d got %h want 40", cyc, seven_seg); end
      tests++; if (frame_tick !== (cyc % 16 == 15)) begin fails++; $display("FAIL scan_tick cyc %0d got %b", cyc, frame_tick); end
    end
  endtask

  task automatic test_load();
    wait_pos(3);
    load_valid = 1'b1; load_data = 16'h12AF;
    step();
    load_valid = 1'b0; load_data = 16'hFFFF;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_drop got %b want 0", load_ready); end
    wait_pos(8);
    tests++; if (seven_seg !== 7'h40) begin fails++; $display("FAIL load_old_value got %h want 40", seven_seg); end
    wait_pos(15);
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL load_ready_rise got %b want 1", load_ready); end
    tests++; if (seven_seg !== 7'h40) begin fails++; $display("FAIL load_boundary_seg got %h want 40", seven_seg); end
    step();
    tests++; if (seven_seg !== 7'h0E || digit_sel !== 4'hE) begin fails++; $display("FAIL load_d0 got %h/%b want 0e/1110", seven_seg, digit_sel); end
    wait_pos(4);
    tests++; if (seven_seg !== 7'h08 || digit_sel !== 4'hD) begin fails++; $display("FAIL load_d1 got %h/%b want 08/1101", seven_seg, digit_sel); end
    wait_pos(8);
    tests++; if (seven_seg !== 7'h24) begin fails++; $display("FAIL load_d2 got %h want 24", seven_seg); end
    wait_pos(12);
    tests++; if (seven_seg !== 7'h79 || digit_sel !== 4'h7) begin fails++; $display("FAIL load_d3 got %h/%b want 79/0111", seven_seg, digit_sel); end
  endtask

  task automatic test_back_to_back();
    load_valid = 1'b1; load_data = 16'h0005;
    step();
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_first_xfer got %b want 0", load_ready); end
    load_data = 16'h0006;
    step();
    step();
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL b2b_commit_ready got %b want 1", load_ready); end
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_second_xfer got %b want 0", load_ready); end
    tests++; if (seven_seg !== 7'h12) begin fails++; $display("FAIL b2b_show5 got %h want 12", seven_seg); end
    wait_pos(4);
    tests++; if (seven_seg !== 7'h40) begin fails++; $display("FAIL b2b_d1 got %h want 40", seven_seg); end
    wait_pos(8);
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_hold got %b want 0", load_ready); end
    wait_pos(15);
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL b2b_commit2 got %b want 1", load_ready); end
    step();
    tests++; if (seven_seg !== 7'h02) begin fails++; $display("FAIL b2b_show6 got %h want 02", seven_seg); end
  endtask

  task automatic test_blank_lz();
    blank_lz = 1'b1;
    load_valid = 1'b1; load_data = 16'h0005;
    step();
    load_valid = 1'b0;
    wait_pos(15);
    step();
    tests++; if (seven_seg !== 7'h12 || digit_sel !== 4'hE) begin fails++; $display("FAIL lz5_d0 got %h/%b want 12/1110", seven_seg, digit_sel); end
    wait_pos(4);
    tests++; if (seven_seg !== 7'h7F || digit_sel !== 4'hD) begin fails++; $display("FAIL lz5_d1 got %h/%b want 7f/1101", seven_seg, digit_sel); end
    wait_pos(8);
    tests++; if (seven_seg !== 7'h7F) begin fails++; $display("FAIL lz5_d2 got %h want 7f", seven_seg); end
    wait_pos(12);
    tests++; if (seven_seg !== 7'h7F || digit_sel !== 4'h7) begin fails++; $display("FAIL lz5_d3 got %h/%b want 7f/0111", seven_seg, digit_sel); end
    load_valid = 1'b1; load_data = 16'h0000;
    step();
    load_valid = 1'b0;
    wait_pos(15);
    step();
    tests++; if (seven_seg !== 7'h40 || digit_sel !== 4'hE) begin fails++; $display("FAIL lz0_d0 got %h/%b want 40/1110", seven_seg, digit_sel); end
    wait_pos(4);
    tests++; if (seven_seg !== 7'h7F) begin fails++; $display("FAIL lz0_d1 got %h want 7f", seven_seg); end
    blank_lz = 1'b0;
    wait_pos(8);
    tests++; if (seven_seg !== 7'h40 || digit_sel !== 4'hB) begin fails++; $display("FAIL lz_off_d2 got %h/%b want 40/1011", seven_seg, digit_sel); end
  endtask

  task automatic test_blink();
    logic [3:0] es;
    logic [6:0] eg;
    wait_pos(15);
    blink_en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (((cyc / 16) / 2) % 2 == 1) begin
        es = 4'hF; eg = 7'h7F;
      end else begin
        es = ~(4'b0001 << ((cyc % 16) / 4)); eg = 7'h40;
      end
      tests++; if (digit_sel !== es) begin fails++; $display("FAIL blink_sel cyc %0d got %b want %b", cyc, digit_sel, es); end
      tests++; if (seven_seg !== eg) begin fails++; $display("FAIL blink_seg cyc %0d got %h want %h", cyc, seven_seg, eg); end
      tests++; if (frame_tick !== (cyc % 16 == 15)) begin fails++; $display("FAIL blink_tick cyc %0d got %b", cyc, frame_tick); end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_reset_pending();
    logic [3:0] es;
    wait_pos(4);
    load_valid = 1'b1; load_data = 16'h8888;
    step();
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL rstp_xfer got %b want 0", load_ready); end
    wait_pos(14);
    rst = 1'b1;
    step();
    tests++; if (digit_sel !== 4'hF || seven_seg !== 7'h7F) begin fails++; $display("FAIL rstp_outputs got %b/%h want 1111/7f", digit_sel, seven_seg); end
    tests++; if (load_ready !== 1'b1 || frame_tick !== 1'b0) begin fails++; $display("FAIL rstp_ready_tick got %b/%b want 1/0", load_ready, frame_tick); end
    rst = 1'b0;
    cyc = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      es = ~(4'b0001 << ((cyc % 16) / 4));
      tests++; if (seven_seg !== 7'h40 || digit_sel !== es) begin fails++; $display("FAIL rstp_scan cyc %0d got %h/%b want 40/%b", cyc, seven_seg, digit_sel, es); end
      tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL rstp_ready cyc %0d got %b want 1", cyc, load_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_blank_lz();
    test_blink();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
